// File: rtl/move_scheduler.sv
// Move scheduler: serialises the blue and red collision queries of each physics
// frame onto a shared collision checker, then releases both movement blocks.
module move_scheduler #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic [9:0] x_blue,
  input  logic [9:0] x_red,
  input  logic [8:0] y_blue,
  input  logic [8:0] y_red,
  output logic       coll_req,
  output logic       coll_id,
  output logic [9:0] coll_x,
  output logic [8:0] coll_y,
  input  logic       coll_ack,
  input  logic [3:0] coll_result,
  output logic [3:0] collision_state_blue,
  output logic [3:0] collision_state_red,
  output logic       upd_strobe,
  output logic       busy,
  output logic       timeout_err,
  output logic [7:0] overrun_cnt
);

  localparam int unsigned XW = 10;
  localparam int unsigned YW = 9;
  localparam int unsigned CW = 8;
  localparam logic [3:0] ON_GROUND = 4'b0001;
  localparam logic [3:0] ALL_BLOCKED = 4'b1111;

  typedef enum logic [1:0] {IDLE, CHK_FIRST, CHK_SECOND, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt;
  logic          order;
  logic [XW-1:0] sec_x;
  logic [YW-1:0] sec_y;
  logic          take_c;
  logic          tmo_c;
  logic          adv_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state; an ack wins over a timeout landing in the same cycle
  always_comb begin
    state_nxt = state;
    take_c    = 1'b0;
    tmo_c     = 1'b0;
    unique case (state)
      IDLE: if (frame_tick) state_nxt = CHK_FIRST;
      CHK_FIRST, CHK_SECOND: begin
        if (coll_ack)                                take_c = 1'b1;
        else if (wait_cnt == CW'(TIMEOUT - 1))       tmo_c  = 1'b1;
        if (take_c || tmo_c) state_nxt = (state == CHK_FIRST) ? CHK_SECOND : DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    adv_c = take_c | tmo_c;
  end

  // Registered outputs, snapshot, wait counter, results and error tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coll_req             <= 1'b0;
      coll_id              <= 1'b0;
      coll_x               <= '0;
      coll_y               <= '0;
      sec_x                <= '0;
      sec_y                <= '0;
      upd_strobe           <= 1'b0;
      busy                 <= 1'b0;
      timeout_err          <= 1'b0;
      overrun_cnt          <= '0;
      order                <= 1'b0;
      wait_cnt             <= '0;
      collision_state_blue <= ON_GROUND;
      collision_state_red  <= ON_GROUND;
    end else begin
      coll_req   <= (state_nxt == CHK_FIRST) || (state_nxt == CHK_SECOND);
      busy       <= (state_nxt != IDLE);
      upd_strobe <= (state_nxt == DONE);

      if ((state == CHK_FIRST || state == CHK_SECOND) && !adv_c) wait_cnt <= wait_cnt + CW'(1);
      else                                                       wait_cnt <= '0;

      if (state == IDLE && frame_tick) begin
        coll_id <= order;
        coll_x  <= order ? x_red  : x_blue;
        coll_y  <= order ? y_red  : y_blue;
        sec_x   <= order ? x_blue : x_red;
        sec_y   <= order ? y_blue : y_red;
      end else if (state == CHK_FIRST && adv_c) begin
        coll_id <= ~coll_id;
        coll_x  <= sec_x;
        coll_y  <= sec_y;
      end

      if (adv_c) begin
        if (coll_id) collision_state_red  <= take_c ? coll_result : ALL_BLOCKED;
        else         collision_state_blue <= take_c ? coll_result : ALL_BLOCKED;
      end
      if (tmo_c) timeout_err <= 1'b1;

      if (state == CHK_SECOND && adv_c) order <= ~order;

      if (frame_tick && state != IDLE && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_move_scheduler.sv
// Self-checking bench for move_scheduler: directed frame table, corner
// sequences and randomized frames against a frame-level timing model.
module tb_move_scheduler;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic [9:0] x_blue, x_red;
  logic [8:0] y_blue, y_red;
  logic       coll_req, coll_id;
  logic [9:0] coll_x;
  logic [8:0] coll_y;
  logic       coll_ack;
  logic [3:0] coll_result;
  logic [3:0] collision_state_blue, collision_state_red;
  logic       upd_strobe, busy, timeout_err;
  logic [7:0] overrun_cnt;

  move_scheduler #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .x_blue(x_blue), .x_red(x_red), .y_blue(y_blue), .y_red(y_red),
    .coll_req(coll_req), .coll_id(coll_id), .coll_x(coll_x), .coll_y(coll_y),
    .coll_ack(coll_ack), .coll_result(coll_result),
    .collision_state_blue(collision_state_blue), .collision_state_red(collision_state_red),
    .upd_strobe(upd_strobe), .busy(busy), .timeout_err(timeout_err), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Frame-level model state
  logic       m_order;
  logic [3:0] m_blue, m_red;
  logic       m_terr;
  int         m_ovr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_order = 1'b0; m_blue = 4'b0001; m_red = 4'b0001; m_terr = 1'b0; m_ovr = 0;
  endtask

  task automatic chk_persist();
    chk("state_blue", 32'(collision_state_blue), 32'(m_blue));
    chk("state_red", 32'(collision_state_red), 32'(m_red));
    chk("timeout_err", 32'(timeout_err), 32'(m_terr));
    chk("overrun_cnt", 32'(overrun_cnt), 32'(m_ovr));
  endtask

  // Idle cycles, optionally with stray acks that must be ignored
  task automatic idle_cycles(input int n, input bit stray);
    for (int i = 0; i < n; i++) begin
      frame_tick  = 1'b0;
      coll_ack    = stray ? 1'($urandom) : 1'b0;
      coll_result = 4'($urandom);
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_req", 32'(coll_req), 32'd0);
      chk("idle_strobe", 32'(upd_strobe), 32'd0);
      chk("idle_blue", 32'(collision_state_blue), 32'(m_blue));
      chk("idle_red", 32'(collision_state_red), 32'(m_red));
      @(posedge clk); #1;
    end
    coll_ack = 1'b0;
  endtask

  // One frame. d1/d2: ack delay in cycles after each check begins (>=TO: no ack).
  // tick_mode: 0 no extra ticks, 1 random, 2 every busy cycle, 3 first three busy cycles.
  task automatic run_frame(input int d1, input int d2, input logic [3:0] r1, input logic [3:0] r2,
                           input int tick_mode, output int lat);
    int l1, l2, fin;
    logic fid;
    logic [9:0] bx, rx;
    logic [8:0] by, ry;
    logic ack_now, tk, in_chk;
    l1  = (d1 < TO) ? d1 + 1 : TO;
    l2  = (d2 < TO) ? d2 + 1 : TO;
    fin = l1 + l2 + 1;
    fid = m_order;
    bx = 10'($urandom); rx = 10'($urandom); by = 9'($urandom); ry = 9'($urandom);
    x_blue = bx; x_red = rx; y_blue = by; y_red = ry;
    frame_tick = 1'b1; coll_ack = 1'b0;
    @(posedge clk); #1;
    lat = -1;
    for (int c = 1; c <= fin + 1; c++) begin
      x_blue = 10'($urandom); x_red = 10'($urandom); y_blue = 9'($urandom); y_red = 9'($urandom);
      ack_now = ((d1 < TO) && (c == 1 + d1)) || ((d2 < TO) && (c == 1 + l1 + d2));
      coll_ack = ack_now;
      coll_result = ack_now ? ((c <= l1) ? r1 : r2) : 4'($urandom);
      case (tick_mode)
        1:       tk = (c <= fin) && (($urandom % 4) == 0);
        2:       tk = (c <= fin);
        3:       tk = (c <= 3);
        default: tk = 1'b0;
      endcase
      frame_tick = tk;
      if (tk && m_ovr < 255) m_ovr++;
      @(negedge clk);
      in_chk = (c <= l1 + l2);
      chk("coll_req", 32'(coll_req), 32'(in_chk));
      if (in_chk) begin
        logic cid;
        cid = (c <= l1) ? fid : ~fid;
        chk("coll_id", 32'(coll_id), 32'(cid));
        chk("coll_x", 32'(coll_x), 32'(cid ? rx : bx));
        chk("coll_y", 32'(coll_y), 32'(cid ? ry : by));
      end
      chk("busy", 32'(busy), 32'(c <= fin));
      chk("upd_strobe", 32'(upd_strobe), 32'(c == fin));
      if (upd_strobe && lat < 0) lat = c;
      @(posedge clk); #1;
    end
    frame_tick = 1'b0; coll_ack = 1'b0;
    if (fid == 1'b0) begin
      m_blue = (d1 < TO) ? r1 : 4'b1111;
      m_red  = (d2 < TO) ? r2 : 4'b1111;
    end else begin
      m_red  = (d1 < TO) ? r1 : 4'b1111;
      m_blue = (d2 < TO) ? r2 : 4'b1111;
    end
    if (d1 >= TO || d2 >= TO) m_terr = 1'b1;
    m_order = ~m_order;
    chk_persist();
  endtask

  typedef struct {
    int         d1, d2;
    logic [3:0] r1, r2;
    int         exp_lat;
    logic [3:0] exp_blue, exp_red;
    logic       exp_terr;
  } vec_t;

  vec_t tbl[4];
  int   lat;

  initial begin
    tbl[0] = '{d1: 0,  d2: 0, r1: 4'b0001, r2: 4'b0100, exp_lat: 3,  exp_blue: 4'b0001, exp_red: 4'b0100, exp_terr: 1'b0};
    tbl[1] = '{d1: 3,  d2: 3, r1: 4'b0010, r2: 4'b1000, exp_lat: 9,  exp_blue: 4'b1000, exp_red: 4'b0010, exp_terr: 1'b0};
    tbl[2] = '{d1: 1,  d2: 0, r1: 4'b0011, r2: 4'b0110, exp_lat: 4,  exp_blue: 4'b0011, exp_red: 4'b0110, exp_terr: 1'b0};
    tbl[3] = '{d1: 15, d2: 2, r1: 4'b0101, r2: 4'b1010, exp_lat: 20, exp_blue: 4'b1010, exp_red: 4'b0101, exp_terr: 1'b0};

    rst_n = 1'b0; frame_tick = 1'b0; coll_ack = 1'b0; coll_result = '0;
    x_blue = '0; x_red = '0; y_blue = '0; y_red = '0;
    model_reset();
    @(negedge clk);
    chk("rst_req", 32'(coll_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobe", 32'(upd_strobe), 32'd0);
    chk_persist();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    idle_cycles(2, 1'b0);

    // Directed frame table
    for (int i = 0; i < 4; i++) begin
      run_frame(tbl[i].d1, tbl[i].d2, tbl[i].r1, tbl[i].r2, 0, lat);
      chk("tbl_lat", 32'(lat), 32'(tbl[i].exp_lat));
      chk("tbl_blue", 32'(collision_state_blue), 32'(tbl[i].exp_blue));
      chk("tbl_red", 32'(collision_state_red), 32'(tbl[i].exp_red));
      chk("tbl_terr", 32'(timeout_err), 32'(tbl[i].exp_terr));
      idle_cycles(1, 1'b0);
    end

    // No ack at all: both checks time out
    run_frame(100, 100, 4'b0, 4'b0, 0, lat);
    chk("to_lat", 32'(lat), 32'd33);
    chk("to_blue", 32'(collision_state_blue), 32'hF);
    chk("to_red", 32'(collision_state_red), 32'hF);
    chk("to_terr", 32'(timeout_err), 32'd1);
    idle_cycles(3, 1'b0);
    chk("to_terr_sticky", 32'(timeout_err), 32'd1);

    // Stray acks while idle
    idle_cycles(6, 1'b1);

    // Overruns: three, then saturate
    run_frame(0, 1, 4'b0010, 4'b0100, 3, lat);
    chk("ovr_3", 32'(overrun_cnt), 32'd3);
    for (int i = 0; i < 10; i++) run_frame(100, 100, 4'b0, 4'b0, 2, lat);
    chk("ovr_sat", 32'(overrun_cnt), 32'd255);
    idle_cycles(2, 1'b0);

    // Reset pulse during the second check
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0; coll_ack = 1'b1; coll_result = 4'b0110;
    @(posedge clk); #1;
    coll_ack = 1'b0;
    @(negedge clk);
    chk("mid_in_chk2", 32'(coll_req), 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(coll_req), 32'd0);
    chk("arst_id", 32'(coll_id), 32'd0);
    chk("arst_x", 32'(coll_x), 32'd0);
    chk("arst_y", 32'(coll_y), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    model_reset();
    chk_persist();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("arst_strobe", 32'(upd_strobe), 32'd0);
    end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    idle_cycles(2, 1'b0);
    run_frame(2, 0, 4'b1001, 4'b0011, 0, lat);
    chk("post_rst_blue", 32'(collision_state_blue), 32'h9);
    chk("post_rst_red", 32'(collision_state_red), 32'h3);

    // Randomized frames
    for (int i = 0; i < 40; i++) begin
      idle_cycles(int'($urandom_range(0, 3)), 1'b1);
      run_frame(int'($urandom_range(0, 19)), int'($urandom_range(0, 19)),
                4'($urandom), 4'($urandom), 1, lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #400000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
